// File: rtl/tdma_slot_scheduler.sv
// Member-side TDMA slot scheduler: counts slots against the cluster head's
// frame_sync and runs one packet-builder request per frame in the own slot.
module tdma_slot_scheduler #(
    parameter int SLOT_CYCLES  = 256,
    parameter int MAX_SLOTS    = 16,
    parameter int GUARD_CYCLES = 8
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        en_pkt,
    input  logic [2:0]  fPktType,
    input  logic        role,
    input  logic        low_E,
    input  logic [15:0] myTimeslot,
    input  logic        frame_sync,
    input  logic        tx_ack,
    output logic [2:0]  state,
    output logic [15:0] slot_idx,
    output logic [15:0] frame_cnt,
    output logic        tx_window,
    output logic        tx_req,
    output logic        sos_flag,
    output logic        tx_miss,
    output logic        sched_err
);

    localparam int CW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam logic [CW-1:0] CYC_LAST = CW'(SLOT_CYCLES - 1);
    localparam logic [CW-1:0] OPEN_LIM = CW'(SLOT_CYCLES - GUARD_CYCLES);
    localparam logic [15:0]   MAX_S    = 16'(MAX_SLOTS);
    localparam logic [15:0]   SLOT_END = 16'(MAX_SLOTS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARMED = 3'd1,
        S_RUN   = 3'd2,
        S_TX    = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    state_e        state_q;
    logic [15:0]   slot_q;
    logic [15:0]   frame_q;
    logic [CW-1:0] cyc_q;
    logic          win_q;
    logic          req_q;
    logic          sos_q;
    logic          latch_q;
    logic          miss_q;
    logic          err_q;

    logic hb;
    logic asg;
    logic slot_ok;
    logic counting;
    logic cyc_term;
    logic wrap;
    logic win_d;
    logic win_rise;
    logic ack_hit;
    logic latch_d;

    // Decode packet strobes and the slot/window conditions of this cycle
    always_comb begin
        hb       = en_pkt && (fPktType == 3'b000);
        asg      = en_pkt && (fPktType == 3'b100);
        slot_ok  = myTimeslot < MAX_S;
        counting = (state_q == S_RUN) || (state_q == S_TX) ||
                   (state_q == S_DONE);
        cyc_term = cyc_q == CYC_LAST;
        wrap     = cyc_term && (slot_q == SLOT_END);
        win_d    = counting && (slot_q == myTimeslot) &&
                   (cyc_q < OPEN_LIM);
        win_rise = win_d && !win_q;
        ack_hit  = (state_q == S_TX) && tx_ack && req_q;
        // an acked SOS request consumes the latch; low_E keeps re-arming it
        latch_d  = (latch_q && !(ack_hit && sos_q)) || low_E;
    end

    // Scheduler FSM with slot/frame counters and registered outputs
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q <= S_IDLE;
            slot_q  <= '0;
            frame_q <= '0;
            cyc_q   <= '0;
            win_q   <= 1'b0;
            req_q   <= 1'b0;
            sos_q   <= 1'b0;
            latch_q <= 1'b0;
            miss_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            miss_q <= 1'b0;
            err_q  <= 1'b0;
            if (role) begin
                state_q <= S_IDLE;
                slot_q  <= '0;
                frame_q <= '0;
                cyc_q   <= '0;
                win_q   <= 1'b0;
                req_q   <= 1'b0;
                sos_q   <= 1'b0;
                latch_q <= 1'b0;
            end else if (hb) begin
                state_q <= S_IDLE;
                win_q   <= 1'b0;
                req_q   <= 1'b0;
                sos_q   <= 1'b0;
            end else if (asg && !slot_ok) begin
                err_q   <= 1'b1;
                state_q <= S_IDLE;
                win_q   <= 1'b0;
                req_q   <= 1'b0;
                sos_q   <= 1'b0;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        if (asg) begin
                            state_q <= S_ARMED;
                            frame_q <= '0;
                        end
                    end
                    S_ARMED: begin
                        if (frame_sync) begin
                            state_q <= S_RUN;
                            slot_q  <= '0;
                            cyc_q   <= '0;
                        end
                    end
                    S_RUN, S_TX, S_DONE: begin
                        win_q   <= win_d;
                        latch_q <= latch_d;
                        if (frame_sync || wrap) begin
                            state_q <= S_RUN;
                            slot_q  <= '0;
                            cyc_q   <= '0;
                            frame_q <= frame_q + 16'd1;
                            if (state_q == S_TX) begin
                                req_q  <= 1'b0;
                                sos_q  <= 1'b0;
                                miss_q <= !ack_hit;
                            end
                        end else begin
                            if (cyc_term) begin
                                cyc_q  <= '0;
                                slot_q <= slot_q + 16'd1;
                            end else begin
                                cyc_q <= cyc_q + CW'(1);
                            end
                            if (state_q == S_RUN && win_rise) begin
                                state_q <= S_TX;
                                req_q   <= 1'b1;
                                sos_q   <= latch_q || low_E;
                            end else if (state_q == S_TX) begin
                                if (ack_hit) begin
                                    state_q <= S_DONE;
                                    req_q   <= 1'b0;
                                    sos_q   <= 1'b0;
                                end else if (!win_d) begin
                                    state_q <= S_DONE;
                                    req_q   <= 1'b0;
                                    sos_q   <= 1'b0;
                                    miss_q  <= 1'b1;
                                end
                            end
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                        win_q   <= 1'b0;
                        req_q   <= 1'b0;
                        sos_q   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign state     = state_q;
    assign slot_idx  = slot_q;
    assign frame_cnt = frame_q;
    assign tx_window = win_q;
    assign tx_req    = req_q;
    assign sos_flag  = sos_q;
    assign tx_miss   = miss_q;
    assign sched_err = err_q;

endmodule

// File: tb/tb_tdma_slot_scheduler.sv
// Bench for tdma_slot_scheduler: a scoreboard of expected request/miss/error
// events (cycle stamp, sos, frame) plus direct state checks.
module tb_tdma_slot_scheduler;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        en_pkt = 1'b0;
    logic [2:0]  fPktType = 3'b111;
    logic        role = 1'b0;
    logic        low_E = 1'b0;
    logic [15:0] myTimeslot = '0;
    logic        frame_sync = 1'b0;
    logic        tx_ack = 1'b0;
    logic [2:0]  state;
    logic [15:0] slot_idx;
    logic [15:0] frame_cnt;
    logic        tx_window;
    logic        tx_req;
    logic        sos_flag;
    logic        tx_miss;
    logic        sched_err;

    tdma_slot_scheduler dut (
        .clk(clk), .nrst(nrst), .en_pkt(en_pkt), .fPktType(fPktType),
        .role(role), .low_E(low_E), .myTimeslot(myTimeslot),
        .frame_sync(frame_sync), .tx_ack(tx_ack), .state(state),
        .slot_idx(slot_idx), .frame_cnt(frame_cnt),
        .tx_window(tx_window), .tx_req(tx_req), .sos_flag(sos_flag),
        .tx_miss(tx_miss), .sched_err(sched_err)
    );

    always #5 clk = ~clk;

    localparam int K_REQ  = 0;
    localparam int K_MISS = 1;
    localparam int K_ERR  = 2;

    typedef struct {
        int          kind;
        int          at;
        logic        sos;
        logic [15:0] frm;
    } ev_t;

    ev_t  sb[$];
    int   ncyc = 0;
    int   nchk = 0;
    int   nerr = 0;
    logic req_prev = 1'b0;

    always @(posedge clk) ncyc++;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, got, exp, ncyc);
        end
    endtask

    task automatic push(input int kind, input int at, input logic sos,
                        input logic [15:0] frm);
        ev_t e;
        e.kind = kind;
        e.at   = at;
        e.sos  = sos;
        e.frm  = frm;
        sb.push_back(e);
    endtask

    task automatic got_ev(input int kind);
        ev_t e;
        if (sb.size() == 0) begin
            chk("sb_unexpected_event", 64'(sb.size()), 64'(1));
            chk("sb_unexpected_kind", 64'(kind), 64'(99));
        end else begin
            e = sb.pop_front();
            chk("sb_kind", 64'(kind), 64'(e.kind));
            chk("sb_cycle", 64'(ncyc), 64'(e.at));
            if (kind == K_REQ) begin
                chk("sb_sos", 64'(sos_flag), 64'(e.sos));
                chk("sb_frame", 64'(frame_cnt), 64'(e.frm));
            end
        end
    endtask

    // Monitor: turn DUT output events into scoreboard pops
    always @(negedge clk) begin
        if (nrst) begin
            if (tx_req && !req_prev) got_ev(K_REQ);
            if (tx_miss) got_ev(K_MISS);
            if (sched_err) got_ev(K_ERR);
        end
        req_prev = tx_req;
    end

    function automatic logic [39:0] outs();
        return {state, slot_idx, frame_cnt, tx_window, tx_req,
                sos_flag, tx_miss, sched_err};
    endfunction

    task automatic at(input int t);
        while (ncyc < t) @(negedge clk);
    endtask

    task automatic asg(input logic [15:0] ts);
        en_pkt = 1'b1;
        fPktType = 3'b100;
        myTimeslot = ts;
        @(negedge clk);
        en_pkt = 1'b0;
        fPktType = 3'b111;
    endtask

    task automatic do_sync(output int e);
        e = ncyc + 1;
        frame_sync = 1'b1;
        @(negedge clk);
        frame_sync = 1'b0;
    endtask

    task automatic pulse_ack();
        tx_ack = 1'b1;
        @(negedge clk);
        tx_ack = 1'b0;
    endtask

    int e;
    int r;
    int w;

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_outputs", outs(), 40'd0);
        nrst = 1'b1;
        @(negedge clk);

        push(K_ERR, ncyc + 1, 1'b0, 16'd0);
        asg(16'd16);
        chk("bad_slot_idle", 64'(state), 64'(0));
        asg(16'd3);
        chk("armed", 64'(state), 64'(1));
        chk("armed_frame", 64'(frame_cnt), 64'(0));

        do_sync(e);
        chk("run_after_sync", 64'(state), 64'(2));
        chk("sync_slot", 64'(slot_idx), 64'(0));
        r = e + 769;
        push(K_REQ, r, 1'b0, 16'd0);
        at(r);
        chk("win_rise", 64'(tx_window), 64'(1));
        chk("tx_state", 64'(state), 64'(3));
        at(r + 5);
        pulse_ack();
        chk("ack_req_drop", 64'(tx_req), 64'(0));
        chk("ack_done", 64'(state), 64'(4));
        at(r + 247);
        chk("win_last_high", 64'(tx_window), 64'(1));
        at(r + 248);
        chk("win_guard_low", 64'(tx_window), 64'(0));

        at(e + 1400);
        do_sync(e);
        chk("frame1", 64'(frame_cnt), 64'(1));
        r = e + 769;
        push(K_REQ, r, 1'b0, 16'd1);
        push(K_MISS, r + 248, 1'b0, 16'd1);
        at(r + 247);
        chk("req_held", 64'(tx_req), 64'(1));
        at(r + 248);
        chk("miss_done", 64'(state), 64'(4));
        chk("miss_req_drop", 64'(tx_req), 64'(0));

        at(e + 1400);
        do_sync(e);
        r = e + 769;
        push(K_REQ, r, 1'b0, 16'd2);
        at(r + 247);
        pulse_ack();
        chk("guard_ack_done", 64'(state), 64'(4));
        chk("guard_ack_req", 64'(tx_req), 64'(0));

        at(e + 4095);
        chk("pre_wrap_slot", 64'(slot_idx), 64'(15));
        chk("pre_wrap_frame", 64'(frame_cnt), 64'(2));
        at(e + 4096);
        chk("wrap_slot", 64'(slot_idx), 64'(0));
        chk("wrap_frame", 64'(frame_cnt), 64'(3));
        chk("wrap_state", 64'(state), 64'(2));
        w = e + 4096;
        r = w + 769;
        push(K_REQ, r, 1'b1, 16'd3);
        at(w + 10);
        low_E = 1'b1;
        repeat (3) @(negedge clk);
        low_E = 1'b0;
        at(r + 1);
        chk("sos_held", 64'(sos_flag), 64'(1));
        at(r + 2);
        pulse_ack();
        chk("sos_clear", 64'(sos_flag), 64'(0));

        at(w + 4095);
        frame_sync = 1'b1;
        @(negedge clk);
        frame_sync = 1'b0;
        chk("coinc_frame", 64'(frame_cnt), 64'(4));
        chk("coinc_slot", 64'(slot_idx), 64'(0));
        w = w + 4096;
        r = w + 769;
        push(K_REQ, r, 1'b0, 16'd4);
        at(r + 3);
        en_pkt = 1'b1;
        fPktType = 3'b000;
        @(negedge clk);
        en_pkt = 1'b0;
        fPktType = 3'b111;
        chk("hb_idle", 64'(state), 64'(0));
        chk("hb_req", 64'(tx_req), 64'(0));
        at(r + 260);

        asg(16'd3);
        chk("rearm", 64'(state), 64'(1));
        do_sync(e);
        at(e + 20);
        chk("role_pre_run", 64'(state), 64'(2));
        role = 1'b1;
        @(negedge clk);
        chk("role_outputs", outs(), 40'd0);
        role = 1'b0;
        @(negedge clk);

        asg(16'd3);
        do_sync(e);
        r = e + 769;
        push(K_REQ, r, 1'b0, 16'd0);
        at(r + 2);
        chk("rst_pre_tx", 64'(state), 64'(3));
        nrst = 1'b0;
        @(negedge clk);
        chk("rst_mid_tx", outs(), 40'd0);
        nrst = 1'b1;
        @(negedge clk);

        chk("sb_left", 64'(sb.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
